// File: rtl/uart_regbank.sv
// UART host-register bank: status/intmask/data/baud registers behind a 2-bit address decode,
// with a DEPTH-entry transmit FIFO drained by the transmitter over a valid/ready handshake.
module uart_regbank #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [DATA_W-1:0] BAUD_RESET = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        addr,
    input  logic              CS,
    input  logic              WE,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] intmask,
    output logic [DATA_W-1:0] baudratedivisor,
    output logic              irq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              rx_event
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q;
    logic              overflow_q, rx_flag_q;
    logic [DATA_W-1:0] rdata_q, intmask_q, baud_q;
    logic              rvalid_q;

    logic              wr, rd, push_req, push, pop, full, empty, ovf_set;
    logic              clr_ovf, clr_rx;
    logic [DATA_W-1:0] status, rsel;

    always_comb begin
        wr       = CS & WE;
        rd       = CS & ~WE;
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        pop      = ~empty & tx_ready;
        push_req = wr & (addr == 2'b10);
        // A push into a full FIFO still lands when the head leaves in the same cycle.
        push     = push_req & (~full | pop);
        ovf_set  = push_req & full & ~pop;
        clr_ovf  = wr & (addr == 2'b00) & in[2];
        clr_rx   = wr & (addr == 2'b00) & in[3];
    end

    always_comb begin
        status    = '0;
        status[0] = empty;
        status[1] = full;
        status[2] = overflow_q;
        status[3] = rx_flag_q;
    end

    always_comb begin
        rsel = '0;
        unique case (addr)
            2'b00: rsel = status;
            2'b01: rsel = intmask_q;
            2'b10: rsel = DATA_W'(count_q);
            2'b11: rsel = baud_q;
        endcase
    end

    // FIFO storage needs no reset; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_flag_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            intmask_q  <= '0;
            baud_q     <= BAUD_RESET;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            // Set has priority over a simultaneous write-1-to-clear.
            overflow_q <= ovf_set | (overflow_q & ~clr_ovf);
            rx_flag_q  <= rx_event | (rx_flag_q & ~clr_rx);
            if (wr && addr == 2'b01) begin
                intmask_q <= in;
            end
            if (wr && addr == 2'b11) begin
                baud_q <= in;
            end
            rvalid_q <= rd;
            if (rd) begin
                rdata_q <= rsel;
            end
        end
    end

    assign rdata           = rdata_q;
    assign rvalid          = rvalid_q;
    assign intmask         = intmask_q;
    assign baudratedivisor = baud_q;
    assign irq             = |(status[3:0] & intmask_q[3:0]);
    assign tx_data         = mem[rptr_q];
    assign tx_valid        = ~empty;

endmodule
